// File: rtl/cnn1d_pkg.sv
// -----------------------------------------------------------------------------
// cnn1d_pkg
// Shared helpers for the 1D CNN datapath blocks.
//   clog2       : ceiling log2 for parameter derivation (clog2(1) = 0)
//   cnn1d_tag_t : container wide enough for any client/tag index in this codebase
//   rr_next     : round-robin successor of a pointer, wrapping modulo n
// -----------------------------------------------------------------------------
package cnn1d_pkg;

    localparam int CNN1D_TAG_MAX_W = 8;

    typedef logic [CNN1D_TAG_MAX_W-1:0] cnn1d_tag_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Successor of ptr in a ring of n entries: ptr+1, or 0 after n-1.
    function automatic cnn1d_tag_t rr_next(input cnn1d_tag_t ptr, input int n);
        if (int'(ptr) + 1 >= n) begin
            return '0;
        end
        return cnn1d_tag_t'(int'(ptr) + 1);
    endfunction

endpackage

// File: rtl/neuron_layer_scheduler_tag_fifo.sv
// -----------------------------------------------------------------------------
// tag_fifo
// Synchronous show-ahead FIFO holding the client tag of each vector that has
// been issued to the neuron layer but whose result has not yet returned.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push, din     : write din when push and not full
//   pop           : discard the head entry when pop and not empty
//   dout          : head entry, valid whenever empty is low (show-ahead)
//   full, empty   : occupancy flags
//   count         : occupancy, 0..DEPTH
// DEPTH must be a power of two (pointers wrap naturally).
// -----------------------------------------------------------------------------
module tag_fifo
    import cnn1d_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic                        full,
    output logic                        empty,
    output logic [clog2(DEPTH+1)-1:0]   count
);

    localparam int AW    = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only read once the
    // count says they were written, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/neuron_layer_scheduler.sv
// -----------------------------------------------------------------------------
// neuron_layer_scheduler
// Shares one parallel neuron layer between NUM_CLIENTS requesters. Input
// vectors are arbitrated round-robin and passed combinationally to the layer;
// the winning client ID is queued in an in-order tag FIFO and attached to the
// matching layer result on the way back.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid/ready/data       : per-client input vectors (client c at slice c)
//   lyr_valid_in/ready_in/data_in : granted vector towards the layer
//   lyr_valid_out/data_out     : per-neuron result valids and result words
//   lyr_ready_out              : result accept towards the layer
//   rsp_valid/ready/id/data    : tagged result to the clients
//   err_orphan                 : sticky, a result arrived with no tag queued
// Optional build macro NEURON_LAYER_SCHEDULER_STATS_EN adds:
//   stat_grants     : per-client saturating issue counters (32 bits each)
//   stat_full_stall : saturating count of cycles stalled by a full tag FIFO
// -----------------------------------------------------------------------------
module neuron_layer_scheduler
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NEURON_INPUTS = 5,
    parameter int NUM_NEURONS   = 32,
    parameter int NUM_CLIENTS   = 4,
    parameter int MAX_INFLIGHT  = 8,
    parameter int ID_WIDTH      = clog2(NUM_CLIENTS)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_CLIENTS-1:0]                      req_valid,
    output logic [NUM_CLIENTS-1:0]                      req_ready,
    input  logic [NUM_CLIENTS*NEURON_INPUTS*DATA_WIDTH-1:0] req_data,
    output logic                                        lyr_valid_in,
    input  logic                                        lyr_ready_in,
    output logic [NEURON_INPUTS*DATA_WIDTH-1:0]         lyr_data_in,
    input  logic [NUM_NEURONS-1:0]                      lyr_valid_out,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0]           lyr_data_out,
    output logic                                        lyr_ready_out,
    output logic                                        rsp_valid,
    input  logic                                        rsp_ready,
    output logic [ID_WIDTH-1:0]                         rsp_id,
    output logic [NUM_NEURONS*DATA_WIDTH-1:0]           rsp_data,
    output logic                                        err_orphan
`ifdef NEURON_LAYER_SCHEDULER_STATS_EN
    ,
    output logic [NUM_CLIENTS*32-1:0]                   stat_grants,
    output logic [31:0]                                 stat_full_stall
`endif
);

    localparam int SLICE_W = NEURON_INPUTS * DATA_WIDTH;
    localparam int CNT_W   = clog2(MAX_INFLIGHT + 1);

    logic [ID_WIDTH-1:0] r_rr_ptr;
    logic                r_err_orphan;

    logic [ID_WIDTH-1:0] w_grant;
    logic [ID_WIDTH-1:0] w_grant_hi;
    logic [ID_WIDTH-1:0] w_grant_lo;
    logic                w_found_hi;
    logic                w_any_valid;
    logic                w_issue_ok;
    logic                w_fire;
    logic                w_res_valid;
    logic                w_tags_avail;
    logic                w_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [ID_WIDTH-1:0] w_fifo_head;
    logic [CNT_W-1:0]    w_fifo_count;
    logic                w_unused_count;

    // Round-robin search: the lowest valid client at or above r_rr_ptr wins;
    // if there is none, the lowest valid client overall (the wrap-around).
    // The loop runs downward so the lowest index is the last one written.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_grant_hi  = '0;
        w_grant_lo  = '0;
        w_found_hi  = 1'b0;
        w_any_valid = 1'b0;
        for (int c = NUM_CLIENTS - 1; c >= 0; c--) begin
            if (req_valid[c]) begin
                w_grant_lo  = ID_WIDTH'(c);
                w_any_valid = 1'b1;
                if (ID_WIDTH'(c) >= r_rr_ptr) begin
                    w_grant_hi = ID_WIDTH'(c);
                    w_found_hi = 1'b1;
                end
            end
        end
        w_grant = w_found_hi ? w_grant_hi : w_grant_lo;
    end

    // Reset is folded into the handshakes so the interface reads idle for the
    // whole time rst is held, not just from the first edge after it.
    assign w_issue_ok   = ~rst & ~w_fifo_full;
    assign lyr_valid_in = w_any_valid & w_issue_ok;
    assign w_fire       = lyr_valid_in & lyr_ready_in;

    always_comb begin
        req_ready   = '0;
        lyr_data_in = '0;
        for (int c = 0; c < NUM_CLIENTS; c++) begin
            if (w_grant == ID_WIDTH'(c)) begin
                req_ready[c] = w_any_valid & w_issue_ok & lyr_ready_in;
                lyr_data_in  = req_data[c*SLICE_W +: SLICE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_fire) begin
            r_rr_ptr <= ID_WIDTH'(rr_next(cnn1d_tag_t'(w_grant), NUM_CLIENTS));
        end
    end

    // Return path: a result is complete only when every neuron reports valid.
    // With no tag queued the result is an orphan and the layer is left stalled.
    assign w_res_valid   = &lyr_valid_out;
    assign w_tags_avail  = ~rst & ~w_fifo_empty;
    assign rsp_valid     = w_res_valid & w_tags_avail;
    assign lyr_ready_out = rsp_ready & w_tags_avail;
    assign rsp_id        = w_fifo_head;
    assign rsp_data      = lyr_data_out;
    assign w_pop         = rsp_valid & rsp_ready;
    assign err_orphan    = r_err_orphan;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_orphan <= 1'b0;
        end else if (w_res_valid & w_fifo_empty) begin
            r_err_orphan <= 1'b1;
        end
    end

    tag_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_fire),
        .pop   (w_pop),
        .din   (w_grant),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // Occupancy is available for debug probing but no logic here needs it.
    assign w_unused_count = ^w_fifo_count;

`ifdef NEURON_LAYER_SCHEDULER_STATS_EN
    logic [31:0] r_stat_grants [NUM_CLIENTS];
    logic [31:0] r_stat_full_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CLIENTS; c++) begin
                r_stat_grants[c] <= '0;
            end
            r_stat_full_stall <= '0;
        end else begin
            for (int c = 0; c < NUM_CLIENTS; c++) begin
                if (w_fire && (w_grant == ID_WIDTH'(c)) && (r_stat_grants[c] != '1)) begin
                    r_stat_grants[c] <= r_stat_grants[c] + 32'd1;
                end
            end
            if (w_any_valid && w_fifo_full && (r_stat_full_stall != '1)) begin
                r_stat_full_stall <= r_stat_full_stall + 32'd1;
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int c = 0; c < NUM_CLIENTS; c++) begin
            stat_grants[c*32 +: 32] = r_stat_grants[c];
        end
    end

    assign stat_full_stall = r_stat_full_stall;
`endif

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_neuron_layer_scheduler
// Drives directed scenarios followed by randomized traffic. A reference model
// (round-robin pointer plus a queue of outstanding client IDs) predicts every
// output each cycle; outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_neuron_layer_scheduler;

    localparam int DW  = 32;
    localparam int NI  = 5;
    localparam int NN  = 32;
    localparam int NC  = 4;
    localparam int MI  = 8;
    localparam int IDW = 2;

    logic                 clk;
    logic                 rst;
    logic [NC-1:0]        req_valid;
    logic [NC-1:0]        req_ready;
    logic [NC*NI*DW-1:0]  req_data;
    logic                 lyr_valid_in;
    logic                 lyr_ready_in;
    logic [NI*DW-1:0]     lyr_data_in;
    logic [NN-1:0]        lyr_valid_out;
    logic [NN*DW-1:0]     lyr_data_out;
    logic                 lyr_ready_out;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [NN*DW-1:0]     rsp_data;
    logic                 err_orphan;
`ifdef NEURON_LAYER_SCHEDULER_STATS_EN
    logic [NC*32-1:0]     stat_grants;
    logic [31:0]          stat_full_stall;
`endif

    neuron_layer_scheduler #(
        .DATA_WIDTH    (DW),
        .NEURON_INPUTS (NI),
        .NUM_NEURONS   (NN),
        .NUM_CLIENTS   (NC),
        .MAX_INFLIGHT  (MI)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .lyr_valid_in  (lyr_valid_in),
        .lyr_ready_in  (lyr_ready_in),
        .lyr_data_in   (lyr_data_in),
        .lyr_valid_out (lyr_valid_out),
        .lyr_data_out  (lyr_data_out),
        .lyr_ready_out (lyr_ready_out),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .err_orphan    (err_orphan)
`ifdef NEURON_LAYER_SCHEDULER_STATS_EN
        ,
        .stat_grants     (stat_grants),
        .stat_full_stall (stat_full_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_rr     = 0;
    int m_q[$];
    bit m_orphan = 1'b0;

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic randomize_req_data();
        for (int w = 0; w < NC * NI; w++) begin
            req_data[w*DW +: DW] = $urandom;
        end
    endtask

    task automatic randomize_lyr_data();
        for (int w = 0; w < NN; w++) begin
            lyr_data_out[w*DW +: DW] = $urandom;
        end
    endtask

    task automatic drive(input logic [NC-1:0] v, input logic lrdy, input logic rrdy, input logic res);
        req_valid     = v;
        lyr_ready_in  = lrdy;
        rsp_ready     = rrdy;
        lyr_valid_out = res ? '1 : '0;
    endtask

    // One clock: compare outputs against the model at the falling edge, then
    // advance the model at the rising edge using the same inputs.
    task automatic cycle();
        int            g;
        bit            any_v;
        bit            full;
        bit            empty;
        bit            res;
        bit            fire;
        bit            pop;
        logic [NC-1:0] e_req_ready;

        @(negedge clk);
        any_v = (req_valid != '0);
        full  = (m_q.size() == MI);
        empty = (m_q.size() == 0);
        res   = (lyr_valid_out == '1);
        g     = 0;
        for (int k = 0; k < NC; k++) begin
            if (req_valid[(m_rr + k) % NC]) begin
                g = (m_rr + k) % NC;
                break;
            end
        end
        fire = 1'b0;
        pop  = 1'b0;

        if (rst) begin
            check("rst_req_ready", 1024'(req_ready), 1024'(0));
            check("rst_lyr_valid_in", 1024'(lyr_valid_in), 1024'(0));
            check("rst_rsp_valid", 1024'(rsp_valid), 1024'(0));
            check("rst_lyr_ready_out", 1024'(lyr_ready_out), 1024'(0));
        end else begin
            fire        = any_v && !full && lyr_ready_in;
            pop         = res && !empty && rsp_ready;
            e_req_ready = '0;
            if (any_v && !full && lyr_ready_in) begin
                e_req_ready[g] = 1'b1;
            end
            check("req_ready", 1024'(req_ready), 1024'(e_req_ready));
            check("lyr_valid_in", 1024'(lyr_valid_in), 1024'(any_v && !full));
            if (any_v) begin
                check("lyr_data_in", 1024'(lyr_data_in), 1024'(req_data[g*NI*DW +: NI*DW]));
            end
            check("rsp_valid", 1024'(rsp_valid), 1024'(res && !empty));
            check("lyr_ready_out", 1024'(lyr_ready_out), 1024'(rsp_ready && !empty));
            if (res && !empty) begin
                check("rsp_id", 1024'(rsp_id), 1024'(m_q[0]));
                check("rsp_data", 1024'(rsp_data), 1024'(lyr_data_out));
            end
        end
        check("err_orphan", 1024'(err_orphan), 1024'(m_orphan));

        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_rr     = 0;
            m_orphan = 1'b0;
        end else begin
            if (res && empty) begin
                m_orphan = 1'b1;
            end
            if (pop) begin
                void'(m_q.pop_front());
            end
            if (fire) begin
                m_q.push_back(g);
                m_rr = (g + 1) % NC;
            end
        end
        #1;
    endtask

    task automatic drain(input int n);
        drive('0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < n; i++) begin
            randomize_lyr_data();
            if (m_q.size() == 0) begin
                lyr_valid_out = '0;
            end
            cycle();
        end
        lyr_valid_out = '0;
    endtask

    initial begin
        rst = 1'b1;
        drive('0, 1'b0, 1'b0, 1'b0);
        req_data     = '0;
        lyr_data_out = '0;

        // Reset state.
        repeat (3) cycle();
        rst = 1'b0;
        cycle();

        // Single client 2 with Q8.24 words 1.0 .. 5.0.
        for (int i = 0; i < NI; i++) begin
            req_data[(2*NI + i)*DW +: DW] = 32'(i + 1) << 24;
        end
        drive(4'b0100, 1'b1, 1'b0, 1'b0);
        cycle();
        drive('0, 1'b1, 1'b0, 1'b0);
        cycle();
        randomize_lyr_data();
        drive('0, 1'b1, 1'b1, 1'b1);
        cycle();

        // All clients valid, results held back: fills the tag FIFO exactly.
        randomize_req_data();
        drive(4'b1111, 1'b1, 1'b0, 1'b0);
        repeat (MI + 3) cycle();
        // One cycle of result acceptance frees a single slot.
        randomize_lyr_data();
        drive(4'b1111, 1'b1, 1'b1, 1'b1);
        cycle();
        drive(4'b1111, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle();
        drain(MI + 2);

        // Layer backpressure with clients 1 and 3 valid.
        randomize_req_data();
        drive(4'b1010, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle();
        drive(4'b1010, 1'b1, 1'b0, 1'b0);
        cycle();
        drain(3);

        // Orphan result with an empty tag FIFO; flag must stick.
        randomize_lyr_data();
        drive('0, 1'b1, 1'b1, 1'b1);
        cycle();
        drive('0, 1'b1, 1'b1, 1'b0);
        repeat (3) cycle();

        // Reset with three tags outstanding, inputs still active.
        drive(4'b1111, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive('0, 1'b0, 1'b0, 1'b0);
        cycle();
        // Discarded tags: a result now is an orphan.
        randomize_lyr_data();
        drive('0, 1'b0, 1'b1, 1'b1);
        cycle();
        drive('0, 1'b0, 1'b0, 1'b0);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            randomize_req_data();
            randomize_lyr_data();
            req_valid     = NC'($urandom);
            lyr_ready_in  = ($urandom_range(0, 3) != 0);
            rsp_ready     = ($urandom_range(0, 2) != 0);
            lyr_valid_out = ($urandom_range(0, 2) == 0) ? NN'($urandom) : '1;
            if (m_q.size() == 0 && $urandom_range(0, 7) != 0) begin
                lyr_valid_out = '0;
            end
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
            end
            cycle();
            rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_layer_scheduler.md
Name: neuron_layer_scheduler

Overview:
- Time-multiplexes one shared parallel neuron layer between NUM_CLIENTS independent requesters, such as per-channel window generators in the 1D CNN.
- Arbitrates input vectors round-robin and forwards the granted vector to the layer's input handshake.
- Records the client ID of each issued vector in an in-order tag FIFO.
- Returns each layer result to its originating client, tagged with that ID.

Parameters:
- DATA_WIDTH, 32, width of one fixed-point word.
- NEURON_INPUTS, 5, words per input vector.
- NUM_NEURONS, 32, words per result vector.
- NUM_CLIENTS, 4, number of requesters (>=2).
- MAX_INFLIGHT, 8, tag FIFO depth: maximum vectors issued but not yet returned (power of 2).
- ID_WIDTH, clog2(NUM_CLIENTS), client tag width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_CLIENTS  per-client input vector valid
- req_ready  out  NUM_CLIENTS  per-client accept
- req_data  in  NUM_CLIENTS*NEURON_INPUTS*DATA_WIDTH  client c occupies slice c*NEURON_INPUTS*DATA_WIDTH upward; word i at +i*DATA_WIDTH
- lyr_valid_in  out  1  vector valid to neuron layer
- lyr_ready_in  in  1  neuron layer ready
- lyr_data_in  out  NEURON_INPUTS*DATA_WIDTH  granted vector
- lyr_valid_out  in  NUM_NEURONS  per-neuron result valid
- lyr_data_out  in  NUM_NEURONS*DATA_WIDTH  layer result
- lyr_ready_out  out  1  result accept to layer
- rsp_valid  out  1  tagged result valid
- rsp_ready  in  1  downstream accept
- rsp_id  out  ID_WIDTH  originating client
- rsp_data  out  NUM_NEURONS*DATA_WIDTH  result, passed through unmodified
- err_orphan  out  1  sticky: result arrived with no outstanding tag

Behaviour:
- Reset values:
  - Round-robin pointer rr_ptr=0; tag FIFO empty.
  - req_ready=0, lyr_valid_in=0, rsp_valid=0, lyr_ready_out=0, err_orphan=0.
- Arbitration (combinational, same cycle):
  - grant = first client with req_valid set, searching upward from rr_ptr and wrapping modulo NUM_CLIENTS.
  - can_issue = any req_valid & !fifo_full.
  - lyr_valid_in = can_issue.
  - lyr_data_in = req_data slice of grant.
  - req_ready[grant] = lyr_ready_in & !fifo_full; all other req_ready bits are 0.
- Issue (fire = lyr_valid_in & lyr_ready_in):
  - Push grant into the tag FIFO.
  - rr_ptr <= grant+1, wrapping to 0 after NUM_CLIENTS-1.
  - No fire means rr_ptr holds and the grant is stable while inputs are stable.
- Issue latency: 0 cycles combinational through to the layer. The layer supplies pipeline registering.
- Return path:
  - res_valid = &lyr_valid_out.
  - rsp_valid = res_valid & !fifo_empty.
  - rsp_id = FIFO head; rsp_data = lyr_data_out.
  - lyr_ready_out = rsp_ready & !fifo_empty.
  - Pop when rsp_valid & rsp_ready.
- Orphan result: res_valid & fifo_empty sets err_orphan (sticky until rst). lyr_ready_out stays 0 in this case, so the layer stalls.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - This is legal even when the FIFO is full, because full blocks the push combinationally.
  - FIFO count range is 0..MAX_INFLIGHT.
- FIFO full: all req_ready=0 and lyr_valid_in=0 until a pop.
- Backpressure:
  - Layer ready_in low: hold the grant; do not advance rr_ptr.
  - rsp_ready low: hold lyr_ready_out low.
- Fairness: with all clients continuously valid, grants cycle 0,1,..,NUM_CLIENTS-1,0.
- Reset mid-operation: the FIFO is discarded. Any results the layer produces before its own reset clears are treated per the orphan rule. The layer shares rst, so none are expected.

Optional Feature:
- Macro: NEURON_LAYER_SCHEDULER_STATS_EN.
- Defined:
  - Extra ports stat_grants (out, NUM_CLIENTS*32): saturating per-client issue counter, incremented on fire for the granted client.
  - stat_full_stall (out, 32): saturating count of cycles with any req_valid & fifo_full.
  - All stat counters reset to 0.
- Undefined: these ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package cnn1d_pkg: clog2 (already present), a new function rr_next(ptr, n), and a typedef for the tag width helper.
- Sub-module: tag_fifo. A synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/din/dout/full/empty/count, and show-ahead dout.

Test Plan:
- Reset, then client 2 only valid, lyr_ready_in=1, data words 1..5 (Q8.24) -> lyr_data_in equals client 2 slice; fire in the same cycle; later result pops with rsp_id=2.
- All 4 clients valid for 8 cycles, layer always ready -> grant sequence 0,1,2,3,0,1,2,3; results return with rsp_id in the same order.
- MAX_INFLIGHT=8, rsp_ready=0, all clients valid -> exactly 8 fires, then req_ready=0 and lyr_valid_in=0; raising rsp_ready for 1 cycle permits exactly 1 new fire.
- lyr_ready_in low for 3 cycles with clients 1 and 3 valid -> grant stays 1, rr_ptr unchanged, no FIFO push.
- Inject &lyr_valid_out with FIFO empty -> err_orphan=1 the next cycle and stays 1; rsp_valid=0; lyr_ready_out=0.
- rst asserted with 3 tags outstanding -> all outputs are at reset values the next cycle, and FIFO count=0.
